// File: rtl/tt_prio_pkg.sv
// Shared types, widths and code decoding for the priority decoder.
//   CODE_W/IDX_W/OUT_W : code, index and one-hot output widths
//   CODE_NONE          : the "no request" code
//   state_t            : pulse sequencer states
//   decode_code()      : code -> {onehot, none, illegal}
package tt_prio_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OUT_W  = 16;
  localparam logic [CODE_W-1:0] CODE_NONE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OUT_W-1:0] onehot;
    logic             none;
    logic             illegal;
  } decode_t;

  // Index codes have a zero high nibble; everything else except CODE_NONE is illegal.
  function automatic decode_t decode_code(input logic [CODE_W-1:0] code);
    decode_t d;
    d = '0;
    if (code[CODE_W-1:IDX_W] == '0) begin
      d.onehot = OUT_W'(1) << code[IDX_W-1:0];
    end else if (code == CODE_NONE) begin
      d.none = 1'b1;
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/tt_prio_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
//   clk, rst_n      : clock, async active-low reset (flushes contents)
//   push_i, data_i  : write request and data (ignored when full)
//   pop_i, data_o   : read request (ignored when empty) and head entry
//   full_o, empty_o : occupancy flags
module tt_prio_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_push = push_i && !r_full;
  assign w_pop  = pop_i && !r_empty;

  // Occupancy update; flags are registered from the next count.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Storage, no reset needed: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule

// File: rtl/tt_priority_decoder.sv
// Buffers encoder codes and replays each as a timed one-hot pulse.
//   clk, rst_n                : clock, async active-low reset
//   code_i/code_valid_i       : code input, accepted when code_ready_o
//   code_ready_o              : code buffer not full
//   onehot_o, none_o          : decoded pulse / "no request" marker
//   active_o                  : high while a code is being held
//   err_o, err_clr_i          : sticky illegal-code flag and its clear
//   evt_cnt_o, cnt_clr_i      : saturating legal-pulse count and its clear
module tt_priority_decoder #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  code_i,
  input  logic        code_valid_i,
  output logic        code_ready_o,
  output logic [15:0] onehot_o,
  output logic        none_o,
  output logic        active_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [7:0]  evt_cnt_o,
  input  logic        cnt_clr_i
);

  import tt_prio_pkg::*;

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned EVT_W   = 8;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [EVT_W-1:0] EVT_MAX   = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [OUT_W-1:0]   r_onehot;
  logic [OUT_W-1:0]   w_onehot_nxt;
  logic               r_none;
  logic               w_none_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic [EVT_W-1:0]   r_evt;
  logic [EVT_W-1:0]   w_evt_nxt;

  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CODE_W-1:0]  w_fifo_data;
  decode_t            w_dec;

  tt_prio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (code_valid_i),
    .data_i  (code_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign w_dec = decode_code(w_fifo_data);

  // Pulse sequencer: pops a code, holds it, then enforces the gap.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_onehot_nxt = r_onehot;
    w_none_nxt   = r_none;
    w_pop        = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_onehot_nxt = '0;
          w_none_nxt   = 1'b0;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else if (!w_fifo_empty) begin
            // No gap configured: reload on the same edge for back-to-back pulses.
            w_pop     = 1'b1;
            w_cnt_nxt = HOLD_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = HOLD;
            w_cnt_nxt   = HOLD_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Load the decoded code on every pop.
    if (w_pop) begin
      w_onehot_nxt = w_dec.onehot;
      w_none_nxt   = w_dec.none;
    end

    // Illegal load wins over a simultaneous clear.
    w_err_nxt = r_err;
    if (err_clr_i) begin
      w_err_nxt = 1'b0;
    end
    if (w_pop && w_dec.illegal) begin
      w_err_nxt = 1'b1;
    end

    // Clear wins over a simultaneous increment.
    w_evt_nxt = r_evt;
    if (w_pop && (|w_dec.onehot) && (r_evt != EVT_MAX)) begin
      w_evt_nxt = r_evt + EVT_W'(1);
    end
    if (cnt_clr_i) begin
      w_evt_nxt = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_onehot <= '0;
      r_none   <= 1'b0;
      r_err    <= 1'b0;
      r_evt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_onehot <= w_onehot_nxt;
      r_none   <= w_none_nxt;
      r_err    <= w_err_nxt;
      r_evt    <= w_evt_nxt;
    end
  end

  assign code_ready_o = !w_fifo_full;
  assign onehot_o     = r_onehot;
  assign none_o       = r_none;
  assign active_o     = (r_state == HOLD);
  assign err_o        = r_err;
  assign evt_cnt_o    = r_evt;

endmodule

// File: tb/tb_tt_priority_decoder.sv
// Self-checking bench for tt_priority_decoder (HOLD=4, GAP=1, DEPTH=2).
// Expected pulses are queued on each accepted code and popped by a monitor
// when a hold window starts.
module tb_tt_priority_decoder;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  code_i;
  logic        code_valid_i;
  logic        code_ready_o;
  logic [15:0] onehot_o;
  logic        none_o;
  logic        active_o;
  logic        err_o;
  logic        err_clr_i;
  logic [7:0]  evt_cnt_o;
  logic        cnt_clr_i;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] oh;
    logic        none;
  } exp_t;

  exp_t sb_q[$];

  tt_priority_decoder #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (1),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .code_ready_o (code_ready_o),
    .onehot_o     (onehot_o),
    .none_o       (none_o),
    .active_o     (active_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i),
    .evt_cnt_o    (evt_cnt_o),
    .cnt_clr_i    (cnt_clr_i)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] c);
    exp_t e;
    e = '0;
    if (c[7:4] == 4'h0) begin
      e.oh = 16'h0001 << c[3:0];
    end else if (c == 8'hF0) begin
      e.none = 1'b1;
    end
    return e;
  endfunction

  // Monitor: compares each hold window against the scoreboard.
  logic        prev_active = 1'b0;
  int          hold_len    = 0;
  logic [15:0] cur_oh      = '0;
  logic        cur_none    = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_active = 1'b0;
      hold_len    = 0;
    end else begin
      checks++;
      if (($countones(onehot_o) > 1) || (none_o && (onehot_o != 16'h0))) begin
        failures++;
        $display("FAIL output_exclusive onehot=%h none=%b", onehot_o, none_o);
      end
      if (active_o && !prev_active) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_pulse onehot=%h none=%b with empty scoreboard", onehot_o, none_o);
        end else begin
          e = sb_q.pop_front();
          if (onehot_o !== e.oh || none_o !== e.none) begin
            failures++;
            $display("FAIL sb_pulse got onehot=%h none=%b expected onehot=%h none=%b",
                     onehot_o, none_o, e.oh, e.none);
          end
        end
        cur_oh   = onehot_o;
        cur_none = none_o;
        hold_len = 1;
      end else if (active_o) begin
        hold_len++;
        checks++;
        if (onehot_o !== cur_oh || none_o !== cur_none) begin
          failures++;
          $display("FAIL hold_stable got onehot=%h none=%b expected onehot=%h none=%b",
                   onehot_o, none_o, cur_oh, cur_none);
        end
      end else if (prev_active) begin
        checks++;
        if (hold_len !== HOLD || onehot_o !== 16'h0 || none_o !== 1'b0) begin
          failures++;
          $display("FAIL hold_end len=%0d onehot=%h none=%b expected len=%0d onehot=0 none=0",
                   hold_len, onehot_o, none_o, HOLD);
        end
      end
      prev_active = active_o;
    end
  end

  // Called just after a negedge; returns just after the following negedge.
  task automatic push_code(input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (code_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout code=%h ready=%b expected 1", c, code_ready_o);
      return;
    end
    code_i       = c;
    code_valid_i = 1'b1;
    @(posedge clk);
    sb_q.push_back(model(c));
    @(negedge clk);
    code_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !active_o) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d active=%b expected 0 and 0", sb_q.size(), active_o);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (onehot_o !== 16'h0 || none_o !== 1'b0 || active_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs onehot=%h none=%b active=%b expected 0/0/0", onehot_o, none_o, active_o);
    end
    checks++;
    if (code_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b expected 1", code_ready_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (onehot_o !== 16'h0 || code_ready_o !== 1'b1 || err_o !== 1'b0 || evt_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL post_reset onehot=%h ready=%b err=%b evt=%0d expected 0/1/0/0",
               onehot_o, code_ready_o, err_o, evt_cnt_o);
    end
  endtask

  task automatic test_single();
    push_code(8'h0F);
    checks++;
    if (active_o !== 1'b0) begin
      failures++;
      $display("FAIL single_latency_early active=%b expected 0", active_o);
    end
    @(negedge clk);
    checks++;
    if (onehot_o !== 16'h8000 || active_o !== 1'b1) begin
      failures++;
      $display("FAIL single_pulse onehot=%h active=%b expected 8000/1", onehot_o, active_o);
    end
    wait_idle();
    checks++;
    if (evt_cnt_o !== 8'd1) begin
      failures++;
      $display("FAIL single_evt got %0d expected 1", evt_cnt_o);
    end
  endtask

  task automatic test_order_backpressure();
    push_code(8'h03);
    push_code(8'h0A);
    push_code(8'h01);
    checks++;
    if (code_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL order_backpressure ready=%b expected 0", code_ready_o);
    end
    push_code(8'h07);
    wait_idle();
    checks++;
    if (evt_cnt_o !== 8'd5) begin
      failures++;
      $display("FAIL order_evt got %0d expected 5", evt_cnt_o);
    end
  endtask

  task automatic test_none();
    push_code(8'hF0);
    @(negedge clk);
    checks++;
    if (none_o !== 1'b1 || onehot_o !== 16'h0) begin
      failures++;
      $display("FAIL none_pulse none=%b onehot=%h expected 1/0000", none_o, onehot_o);
    end
    wait_idle();
    checks++;
    if (evt_cnt_o !== 8'd5 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL none_side_effects evt=%0d err=%b expected 5/0", evt_cnt_o, err_o);
    end
  endtask

  task automatic test_illegal();
    push_code(8'h35);
    wait_idle();
    checks++;
    if (err_o !== 1'b1 || evt_cnt_o !== 8'd5) begin
      failures++;
      $display("FAIL illegal_sticky err=%b evt=%0d expected 1/5", err_o, evt_cnt_o);
    end
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clear err=%b expected 0", err_o);
    end
    // Clear asserted on the load edge of a second illegal code.
    push_code(8'h35);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL illegal_set_priority err=%b expected 1", err_o);
    end
    wait_idle();
    err_clr_i = 1'b1;
    cnt_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    cnt_clr_i = 1'b0;
    checks++;
    if (evt_cnt_o !== 8'd0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL counter_clear evt=%0d err=%b expected 0/0", evt_cnt_o, err_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      push_code(8'(i % 16));
    end
    wait_idle();
    checks++;
    if (evt_cnt_o !== 8'd255) begin
      failures++;
      $display("FAIL evt_saturate got %0d expected 255", evt_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    push_code(8'h02);
    push_code(8'h04);
    push_code(8'h06);
    checks++;
    if (onehot_o !== 16'h0004 || active_o !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre onehot=%h active=%b expected 0004/1", onehot_o, active_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (onehot_o !== 16'h0 || active_o !== 1'b0 || none_o !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate onehot=%h active=%b none=%b expected 0/0/0",
               onehot_o, active_o, none_o);
    end
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (active_o || onehot_o != 16'h0 || none_o) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL areset_flush pulses_seen=%0d expected 0", bad);
    end
    checks++;
    if (evt_cnt_o !== 8'd0 || code_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL areset_state evt=%0d ready=%b expected 0/1", evt_cnt_o, code_ready_o);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    code_i       = 8'h00;
    code_valid_i = 1'b0;
    err_clr_i    = 1'b0;
    cnt_clr_i    = 1'b0;
    test_reset();
    test_single();
    test_order_backpressure();
    test_none();
    test_illegal();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
